// File: rtl/axi_fifo_wr_packer_if.sv
// Pixel-stream input and FIFO write port of the write-side packer.
// The packer takes the slave side; the producer/FIFO environment takes the master side.
interface axi_fifo_wr_packer_if #(
    parameter int IN_W  = 16,
    parameter int RATIO = 4
);
    localparam int OUT_W = IN_W * RATIO;

    logic              s_valid;
    logic [IN_W-1:0]   s_data;
    logic              s_last;
    logic              s_ready;
    logic [OUT_W-1:0]  fifo_wr_data;
    logic [RATIO-1:0]  fifo_wr_keep;
    logic              fifo_wr_en;
    logic              fifo_wr_vld;

    modport slave (
        input  s_valid, s_data, s_last, fifo_wr_vld,
        output s_ready, fifo_wr_data, fifo_wr_keep, fifo_wr_en
    );

    modport master (
        output s_valid, s_data, s_last, fifo_wr_vld,
        input  s_ready, fifo_wr_data, fifo_wr_keep, fifo_wr_en
    );
endinterface

// File: rtl/axi_fifo_wr_packer.sv
// Packs RATIO narrow beats LSB-first into one FIFO word, with a 2-entry
// output queue for FIFO backpressure and zero-padded flush on s_last.
module axi_fifo_wr_packer #(
    parameter int IN_W  = 16,
    parameter int RATIO = 4,
    parameter int OUT_W = IN_W * RATIO,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_fifo_wr_packer_if.slave bus,
    output logic             line_done,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int E_W   = OUT_W + RATIO + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] acc_data;
    logic [OUT_W-1:0] nxt_data;
    logic [RATIO-1:0] acc_keep;
    logic [RATIO-1:0] nxt_keep;
    // Queue entries are {last, keep, data}; hd is always the oldest word.
    logic [E_W-1:0]   hd;
    logic [E_W-1:0]   tl;
    logic [E_W-1:0]   new_ent;
    logic [1:0]       q_cnt;
    logic             s_ready;
    logic             acc;
    logic             push;
    logic             pop;

    assign s_ready     = (q_cnt < 2'd2);
    assign bus.s_ready = s_ready;
    assign acc         = bus.s_valid & s_ready;
    assign push        = acc & ((idx == LAST_IDX) | bus.s_last);
    // Gated by rst_n so the FIFO never sees a write in the reset cycle.
    assign pop         = rst_n & (q_cnt != 2'd0) & bus.fifo_wr_vld;

    assign bus.fifo_wr_en   = pop;
    assign bus.fifo_wr_data = (q_cnt != 2'd0) ? hd[OUT_W-1:0] : '0;
    assign bus.fifo_wr_keep = (q_cnt != 2'd0) ? hd[OUT_W +: RATIO] : '0;

    always_comb begin
        nxt_data = acc_data;
        nxt_keep = acc_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (idx == IDX_W'(i)) begin
                nxt_data[i*IN_W +: IN_W] = bus.s_data;
                nxt_keep[i]              = 1'b1;
            end
        end
    end

    assign new_ent = {bus.s_last, nxt_keep, nxt_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            acc_data  <= '0;
            acc_keep  <= '0;
            hd        <= '0;
            tl        <= '0;
            q_cnt     <= 2'd0;
            word_cnt  <= '0;
            line_done <= 1'b0;
        end else begin
            if (acc) begin
                if (push) begin
                    idx      <= '0;
                    acc_data <= '0;
                    acc_keep <= '0;
                end else begin
                    idx      <= idx + IDX_W'(1);
                    acc_data <= nxt_data;
                    acc_keep <= nxt_keep;
                end
            end

            case ({push, pop})
                2'b10: begin
                    if (q_cnt == 2'd0) hd <= new_ent;
                    else               tl <= new_ent;
                    q_cnt <= q_cnt + 2'd1;
                end
                2'b01: begin
                    hd    <= tl;
                    tl    <= '0;
                    q_cnt <= q_cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (q_cnt == 2'd1) begin
                        hd <= new_ent;
                    end else begin
                        hd <= tl;
                        tl <= new_ent;
                    end
                end
                default: ;
            endcase

            line_done <= pop & hd[E_W-1];
            word_cnt  <= word_cnt + CNT_W'(pop);
        end
    end
endmodule
